spike_scheduler: RTL and testbench
==================================

SPIKE_SCHEDULER -- requirements
Module: spike_scheduler

Interface
REQ-001 Parameter WEIGHT_1, default 4'd5, current contributed by one channel-0 spike event.
REQ-002 Parameter WEIGHT_2, default 4'd4, current contributed by one channel-1 spike event.
REQ-003 Parameter WEIGHT_3, default 4'd3, current contributed by one channel-2 spike event.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 spike_in  input  3  per-channel spike level; each cycle high is one event.
REQ-007 enable  input  1  permits new grants when high.
REQ-008 current_ready  input  1  downstream neuron accepts current_out.
REQ-009 current_out  output  4  registered weighted current to the downstream LIF neuron.
REQ-010 current_valid  output  1  current_out is valid.
REQ-011 grant  output  3  one-hot channel of the current transfer; 0 when idle.
REQ-012 pending  output  3  bit i high when channel i has a nonzero event count.
REQ-013 overflow  output  1  sticky flag for a lost event.

Function
REQ-014 Each channel SHALL hold a 2-bit event counter, incremented on each clk with spike_in[i]=1 and saturating at 3.
REQ-015 A spike arriving on a saturated counter SHALL be dropped and SHALL set overflow, which stays set until reset.
REQ-016 The FSM SHALL have states IDLE, ARB and HOLD.
REQ-017 IDLE->ARB SHALL occur when enable=1 and any counter is nonzero.
REQ-018 In ARB the block SHALL pick one nonzero channel by round-robin starting at pointer rr_ptr (reset 0).
- Outputs: current_out=weight of the pick, grant=one-hot pick, current_valid=1.
- Registered effect: the pick's counter decrements and rr_ptr becomes pick+1 mod 3.
- The FSM then goes to HOLD.
REQ-019 In HOLD, current_out and grant SHALL be held stable while current_valid=1 and current_ready=0.
REQ-020 In HOLD with current_ready=1, the transfer SHALL complete that cycle.
- Next state is ARB if enable=1 and any counter is nonzero; otherwise IDLE with current_valid=0, grant=0, current_out=0.
REQ-021 Back-to-back transfers SHALL sustain one transfer per cycle when current_ready stays high: ARB to HOLD, then HOLD with current_ready=1 to ARB.
REQ-022 A spike and a grant decrement on the same channel in the same cycle SHALL leave the counter unchanged, including at saturation (no overflow).
REQ-023 enable falling SHALL NOT abort a transfer in HOLD.
- No new ARB follows while enable=0.
- Counters keep accumulating while enable=0.
REQ-024 Latency SHALL be that a spike on idle channels with enable=1 appears as current_valid=1 two clks later (count, then ARB).

Reset
REQ-025 While reset=0 the block SHALL asynchronously clear all of the following:
- counters, rr_ptr and overflow;
- FSM to IDLE;
- current_out=0, current_valid=0, grant=0, pending=0.
REQ-026 Reset asserted mid-HOLD SHALL discard the in-flight transfer.
REQ-027 The first clk after reset deasserts SHALL sample spike_in normally.

Configuration
REQ-028 Macro SPIKE_SCHED_COALESCE_EN SHALL be the only compile option.
REQ-029 With SPIKE_SCHED_COALESCE_EN defined, an ARB pick whose counter is >=2 SHALL issue min(2*weight,15) and decrement that counter by 2.
REQ-030 Without SPIKE_SCHED_COALESCE_EN, every ARB pick SHALL issue weight and decrement by 1.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, ARB, HOLD), the 4-bit current width constant, the 2-bit counter width and the counter maximum 3.
REQ-032 The round-robin selector SHALL be one sub-module, rr_select3, with inputs request[2:0] and rr_ptr and output one-hot pick.

Verification
REQ-033 Reset released, then spike_in=3'b001 for 1 clk, enable=1, current_ready=1 -> two clks later current_valid=1, current_out=5, grant=001 for one cycle.
REQ-034 spike_in=3'b111 for 1 clk, current_ready=1 -> transfers grant 001/5, 010/4, 100/3 on consecutive cycles, then IDLE.
REQ-035 current_ready=0 during a transfer of current_out=4 for 5 clks -> current_out=4 and grant=010 held, no new grant; then current_ready=1 completes it.
REQ-036 enable=0 and spike_in[0]=1 for 4 clks -> counter 3, overflow=1, pending=001; enable=1 then yields three transfers of 5 (coalesce off) or 10 then 5 (SPIKE_SCHED_COALESCE_EN).
REQ-037 spike_in[1]=1 held while channel 1 is granted with current_ready=1 -> counter steady, one transfer of 4 per cycle, overflow=0.
REQ-038 reset=0 asserted mid-HOLD -> outputs zero immediately (asynchronously), and no stale transfer after release.

Source files
------------

// File: rtl/spike_scheduler_pkg.sv
// Shared FSM state, widths and helpers for the spike scheduler.
package spike_scheduler_pkg;

   typedef enum logic [1:0] {IDLE, ARB, HOLD} state_t;

   localparam int               CUR_W   = 4;
   localparam int               CNT_W   = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;
   localparam int               NUM_CH  = 3;

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction

   // Doubled weight, clamped to the current range.
   function automatic logic [CUR_W-1:0] double_sat(input logic [CUR_W-1:0] w);
      logic [CUR_W:0] d;
      d = {w, 1'b0};
      return d[CUR_W] ? '1 : d[CUR_W-1:0];
   endfunction

endpackage

// File: rtl/rr_select3.sv
// Round-robin selector over three requesters; the search starts at rr_ptr.
module rr_select3
   import spike_scheduler_pkg::*;
(
   input  logic [2:0] request,
   input  logic [1:0] rr_ptr,
   output logic [2:0] pick
);

   logic [1:0] cand [3];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_cand
         assign cand[gi] = wrap3({1'b0, rr_ptr} + 3'(gi));
      end
   endgenerate

   // Lowest priority first, so the candidate nearest the pointer is written last.
   always_comb begin
      pick = '0;
      for (int k = 2; k >= 0; k--) begin
         if (request[cand[k]]) begin
            pick = 3'b001 << cand[k];
         end
      end
   end

endmodule

// File: rtl/spike_scheduler.sv
// Three-channel spike event scheduler delivering weighted current to a LIF neuron.
// Compile option SPIKE_SCHED_COALESCE_EN: a pick with two or more queued events issues a doubled current.
module spike_scheduler
   import spike_scheduler_pkg::*;
#(
   parameter logic [CUR_W-1:0] WEIGHT_1 = 4'd5,
   parameter logic [CUR_W-1:0] WEIGHT_2 = 4'd4,
   parameter logic [CUR_W-1:0] WEIGHT_3 = 4'd3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       spike_in,
   input  logic             enable,
   input  logic             current_ready,
   output logic [CUR_W-1:0] current_out,
   output logic             current_valid,
   output logic [2:0]       grant,
   output logic [2:0]       pending,
   output logic             overflow
);

   state_t                       state_reg;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_reg;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_next;
   logic [NUM_CH-1:0][CUR_W-1:0] chan_current;
   logic [NUM_CH-1:0][CNT_W-1:0] chan_dec;
   logic [NUM_CH-1:0]            lost;
   logic [1:0]                   rr_ptr_reg;
   logic [1:0]                   rr_ptr_next;
   logic                         overflow_reg;
   logic [CUR_W-1:0]             current_out_reg;
   logic                         current_valid_reg;
   logic [2:0]                   grant_reg;
   logic [2:0]                   pick;
   logic [CUR_W-1:0]             pick_current;
   logic                         issue_pick;

   rr_select3 u_rr_select3 (
      .request (pending),
      .rr_ptr  (rr_ptr_reg),
      .pick    (pick)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
         localparam logic [CUR_W-1:0] WEIGHT = (gi == 0) ? WEIGHT_1 :
                                               (gi == 1) ? WEIGHT_2 : WEIGHT_3;
         logic           take_two;
         logic [CNT_W:0] sum;
`ifdef SPIKE_SCHED_COALESCE_EN
         assign take_two = (cnt_reg[gi] >= 2'd2);
`else
         assign take_two = 1'b0;
`endif
         assign chan_current[gi] = take_two ? double_sat(WEIGHT) : WEIGHT;
         assign chan_dec[gi]     = take_two ? 2'd2 : 2'd1;
         // Spike and grant in the same cycle cancel, so only a net gain past the maximum is lost.
         assign sum = {1'b0, cnt_reg[gi]} + {{CNT_W{1'b0}}, spike_in[gi]}
                    - ((issue_pick && pick[gi]) ? {1'b0, chan_dec[gi]} : '0);
         assign lost[gi]     = (sum > {1'b0, CNT_MAX});
         assign cnt_next[gi] = lost[gi] ? CNT_MAX : sum[CNT_W-1:0];
         assign pending[gi]  = |cnt_reg[gi];
      end
   endgenerate

   always_comb begin
      pick_current = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pick[i]) begin
            pick_current = pick_current | chan_current[i];
         end
      end
   end

   assign rr_ptr_next = pick[0] ? 2'd1 : (pick[1] ? 2'd2 : 2'd0);

   // The output slot is free when idle or when the shown transfer is accepted this cycle.
   assign issue_pick = ((state_reg == IDLE) || current_ready) && enable && (|pending);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg      <= '0;
         overflow_reg <= 1'b0;
      end else begin
         cnt_reg      <= cnt_next;
         overflow_reg <= overflow_reg | (|lost);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg         <= IDLE;
         rr_ptr_reg        <= 2'd0;
         current_out_reg   <= '0;
         current_valid_reg <= 1'b0;
         grant_reg         <= '0;
      end else if (issue_pick) begin
         state_reg         <= ARB;
         rr_ptr_reg        <= rr_ptr_next;
         current_out_reg   <= pick_current;
         current_valid_reg <= 1'b1;
         grant_reg         <= pick;
      end else begin
         case (state_reg)
            ARB, HOLD: begin
               if (current_ready) begin
                  state_reg         <= IDLE;
                  current_out_reg   <= '0;
                  current_valid_reg <= 1'b0;
                  grant_reg         <= '0;
               end else begin
                  state_reg <= HOLD;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign current_out   = current_out_reg;
   assign current_valid = current_valid_reg;
   assign grant         = grant_reg;
   assign overflow      = overflow_reg;

endmodule

// File: tb/tb_spike_scheduler.sv
// Self-checking bench for spike_scheduler: vector table, directed corner sequences, random vs model.
module tb_spike_scheduler;

   logic       clk;
   logic       reset;
   logic [2:0] spike_in;
   logic       enable;
   logic       current_ready;
   logic [3:0] current_out;
   logic       current_valid;
   logic [2:0] grant;
   logic [2:0] pending;
   logic       overflow;

   int total = 0;
   int bad   = 0;

`ifdef SPIKE_SCHED_COALESCE_EN
   localparam bit COALESCE = 1'b1;
`else
   localparam bit COALESCE = 1'b0;
`endif

   spike_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .spike_in      (spike_in),
      .enable        (enable),
      .current_ready (current_ready),
      .current_out   (current_out),
      .current_valid (current_valid),
      .grant         (grant),
      .pending       (pending),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] spike;
      logic       en;
      logic       rdy;
      logic       exp_v;
      logic [3:0] exp_out;
      logic [2:0] exp_g;
      logic [2:0] exp_p;
      logic       exp_ov;
   } vec_t;

   vec_t vecs [13];

   // Behavioural model: event counts, round-robin pointer, and the transfer currently shown.
   int m_cnt [3];
   int m_rr;
   bit m_ovf;
   bit m_valid;
   int m_ch;
   int m_amt;

   function automatic int weight_of(input int c);
      return (c == 0) ? 5 : (c == 1) ? 4 : 3;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_rr = 0; m_ovf = 0; m_valid = 0; m_ch = 0; m_amt = 0;
   endfunction

   function automatic void model_edge(input logic [2:0] sp, input logic en, input logic rdy);
      int take [3];
      int any;
      int found;
      int c;
      take = '{0, 0, 0};
      any = 0;
      for (int i = 0; i < 3; i++) if (m_cnt[i] > 0) any = 1;
      if ((!m_valid || rdy) && en && any != 0) begin
         found = 0;
         for (int k = 0; k < 3; k++) begin
            c = (m_rr + k) % 3;
            if (found == 0 && m_cnt[c] > 0) begin
               found = 1;
               m_ch = c;
               if (COALESCE && m_cnt[c] >= 2) begin
                  take[c] = 2;
                  m_amt = (2 * weight_of(c) > 15) ? 15 : 2 * weight_of(c);
               end else begin
                  take[c] = 1;
                  m_amt = weight_of(c);
               end
               m_rr = (c + 1) % 3;
            end
         end
         m_valid = 1;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = m_cnt[i] + int'(sp[i]) - take[i];
         if (m_cnt[i] > 3) begin
            m_cnt[i] = 3;
            m_ovf = 1;
         end
      end
   endfunction

   function automatic logic [11:0] model_expect();
      logic [2:0] p;
      logic [2:0] g;
      logic [3:0] o;
      p = '0; g = '0; o = '0;
      for (int i = 0; i < 3; i++) p[i] = (m_cnt[i] > 0);
      if (m_valid) begin
         g[m_ch] = 1'b1;
         o = 4'(m_amt);
      end
      return {m_valid, o, g, p, m_ovf};
   endfunction

   function automatic logic [11:0] pk(input logic v, input logic [3:0] o, input logic [2:0] g,
                                      input logic [2:0] p, input logic ov);
      return {v, o, g, p, ov};
   endfunction

   task automatic check(input string name, input logic [11:0] exp);
      logic [11:0] act;
      act = {current_valid, current_out, grant, pending, overflow};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got valid=%0b out=%0d grant=%b pending=%b ovf=%0b, want valid=%0b out=%0d grant=%b pending=%b ovf=%0b",
                  name, act[11], act[10:7], act[6:4], act[3:1], act[0],
                  exp[11], exp[10:7], exp[6:4], exp[3:1], exp[0]);
      end else begin
         $display("txn %s: valid=%0b out=%0d grant=%b pending=%b ovf=%0b",
                  name, act[11], act[10:7], act[6:4], act[3:1], act[0]);
      end
   endtask

   task automatic tick_check(input string name, input logic [11:0] exp);
      @(posedge clk);
      #1;
      check(name, exp);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      spike_in = '0; enable = 1'b0; current_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   logic [11:0] ovf_exp [4];
   logic [11:0] sat_exp [3];
   logic [2:0]  r_sp;
   logic        r_en;
   logic        r_rdy;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{3'b111, 1'b1, 1'b1, 1'b0, 4'd0, 3'b000, 3'b111, 1'b0};
      vecs[1]  = '{3'b000, 1'b1, 1'b1, 1'b1, 4'd5, 3'b001, 3'b110, 1'b0};
      vecs[2]  = '{3'b000, 1'b1, 1'b1, 1'b1, 4'd4, 3'b010, 3'b100, 1'b0};
      vecs[3]  = '{3'b000, 1'b1, 1'b1, 1'b1, 4'd3, 3'b100, 3'b000, 1'b0};
      vecs[4]  = '{3'b000, 1'b1, 1'b1, 1'b0, 4'd0, 3'b000, 3'b000, 1'b0};
      vecs[5]  = '{3'b010, 1'b1, 1'b0, 1'b0, 4'd0, 3'b000, 3'b010, 1'b0};
      vecs[6]  = '{3'b000, 1'b1, 1'b0, 1'b1, 4'd4, 3'b010, 3'b000, 1'b0};
      vecs[7]  = '{3'b001, 1'b1, 1'b0, 1'b1, 4'd4, 3'b010, 3'b001, 1'b0};
      vecs[8]  = '{3'b000, 1'b1, 1'b0, 1'b1, 4'd4, 3'b010, 3'b001, 1'b0};
      vecs[9]  = '{3'b000, 1'b1, 1'b0, 1'b1, 4'd4, 3'b010, 3'b001, 1'b0};
      vecs[10] = '{3'b000, 1'b1, 1'b0, 1'b1, 4'd4, 3'b010, 3'b001, 1'b0};
      vecs[11] = '{3'b000, 1'b1, 1'b1, 1'b1, 4'd5, 3'b001, 3'b000, 1'b0};
      vecs[12] = '{3'b000, 1'b1, 1'b1, 1'b0, 4'd0, 3'b000, 3'b000, 1'b0};

`ifdef SPIKE_SCHED_COALESCE_EN
      ovf_exp = '{pk(1'b1, 4'd10, 3'b001, 3'b001, 1'b1), pk(1'b1, 4'd5, 3'b001, 3'b000, 1'b1),
                  pk(1'b0, 4'd0, 3'b000, 3'b000, 1'b1),  pk(1'b0, 4'd0, 3'b000, 3'b000, 1'b1)};
      sat_exp = '{pk(1'b1, 4'd8, 3'b010, 3'b010, 1'b0), pk(1'b1, 4'd8, 3'b010, 3'b010, 1'b0),
                  pk(1'b1, 4'd4, 3'b010, 3'b010, 1'b0)};
`else
      ovf_exp = '{pk(1'b1, 4'd5, 3'b001, 3'b001, 1'b1), pk(1'b1, 4'd5, 3'b001, 3'b001, 1'b1),
                  pk(1'b1, 4'd5, 3'b001, 3'b000, 1'b1), pk(1'b0, 4'd0, 3'b000, 3'b000, 1'b1)};
      sat_exp = '{pk(1'b1, 4'd4, 3'b010, 3'b010, 1'b0), pk(1'b1, 4'd4, 3'b010, 3'b010, 1'b0),
                  pk(1'b1, 4'd4, 3'b010, 3'b010, 1'b0)};
`endif

      reset = 1'b1; spike_in = '0; enable = 1'b0; current_ready = 1'b0;
      #2 reset = 1'b0;
      #1 check("reset_state", pk(1'b0, 4'd0, 3'b000, 3'b000, 1'b0));
      @(negedge clk);
      reset = 1'b1;

      // Latency, three-way round robin, stall with held outputs, then release.
      for (int i = 0; i < 13; i++) begin
         spike_in = vecs[i].spike; enable = vecs[i].en; current_ready = vecs[i].rdy;
         tick_check($sformatf("vec%0d", i),
                    pk(vecs[i].exp_v, vecs[i].exp_out, vecs[i].exp_g, vecs[i].exp_p, vecs[i].exp_ov));
      end

      // Saturation with enable low, then drain.
      do_reset();
      enable = 1'b0; current_ready = 1'b1; spike_in = 3'b001;
      for (int i = 0; i < 4; i++)
         tick_check($sformatf("ovf_fill%0d", i), pk(1'b0, 4'd0, 3'b000, 3'b001, (i == 3)));
      enable = 1'b1; spike_in = 3'b000;
      for (int i = 0; i < 4; i++) tick_check($sformatf("ovf_drain%0d", i), ovf_exp[i]);

      // Spike held on the granted channel: steady count, one transfer per cycle.
      do_reset();
      enable = 1'b1; current_ready = 1'b1; spike_in = 3'b010;
      tick_check("steady_first", pk(1'b0, 4'd0, 3'b000, 3'b010, 1'b0));
      for (int i = 0; i < 5; i++)
         tick_check($sformatf("steady%0d", i), pk(1'b1, 4'd4, 3'b010, 3'b010, 1'b0));
      spike_in = 3'b000;
      tick_check("steady_last", pk(1'b1, 4'd4, 3'b010, 3'b000, 1'b0));
      tick_check("steady_idle", pk(1'b0, 4'd0, 3'b000, 3'b000, 1'b0));

      // Spike plus grant on a saturated counter must not overflow.
      do_reset();
      enable = 1'b0; current_ready = 1'b1; spike_in = 3'b010;
      for (int i = 0; i < 3; i++)
         tick_check($sformatf("sat_fill%0d", i), pk(1'b0, 4'd0, 3'b000, 3'b010, 1'b0));
      enable = 1'b1;
      for (int i = 0; i < 3; i++) tick_check($sformatf("sat_hold%0d", i), sat_exp[i]);

      // Enable dropping during HOLD finishes the transfer but starts no new one.
      do_reset();
      enable = 1'b1; current_ready = 1'b0; spike_in = 3'b011;
      tick_check("en_count", pk(1'b0, 4'd0, 3'b000, 3'b011, 1'b0));
      spike_in = 3'b000;
      tick_check("en_grant", pk(1'b1, 4'd5, 3'b001, 3'b010, 1'b0));
      enable = 1'b0;
      tick_check("en_hold", pk(1'b1, 4'd5, 3'b001, 3'b010, 1'b0));
      current_ready = 1'b1;
      tick_check("en_done", pk(1'b0, 4'd0, 3'b000, 3'b010, 1'b0));
      tick_check("en_quiet", pk(1'b0, 4'd0, 3'b000, 3'b010, 1'b0));
      enable = 1'b1;
      tick_check("en_resume", pk(1'b1, 4'd4, 3'b010, 3'b000, 1'b0));

      // Asynchronous reset in the middle of a stalled transfer.
      do_reset();
      enable = 1'b1; current_ready = 1'b0; spike_in = 3'b001;
      tick_check("rst_count", pk(1'b0, 4'd0, 3'b000, 3'b001, 1'b0));
      spike_in = 3'b000;
      tick_check("rst_grant", pk(1'b1, 4'd5, 3'b001, 3'b000, 1'b0));
      #2 reset = 1'b0;
      #1 check("rst_async", pk(1'b0, 4'd0, 3'b000, 3'b000, 1'b0));
      @(negedge clk);
      reset = 1'b1; current_ready = 1'b1; spike_in = 3'b100;
      tick_check("rst_first_clk", pk(1'b0, 4'd0, 3'b000, 3'b100, 1'b0));
      spike_in = 3'b000;
      tick_check("rst_new", pk(1'b1, 4'd3, 3'b100, 3'b000, 1'b0));
      tick_check("rst_idle", pk(1'b0, 4'd0, 3'b000, 3'b000, 1'b0));

      // Random traffic against the model, three traffic mixes.
      for (int seg = 0; seg < 3; seg++) begin
         do_reset();
         for (int n = 0; n < 100; n++) begin
            if (seg == 0) r_sp = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            else          r_sp = 3'($urandom_range(0, 7));
            if (seg == 2) r_en = 1'($urandom_range(0, 1));
            else          r_en = ($urandom_range(0, 7) != 0);
            if (seg == 1) r_rdy = 1'($urandom_range(0, 1));
            else          r_rdy = ($urandom_range(0, 3) != 0);
            spike_in = r_sp; enable = r_en; current_ready = r_rdy;
            @(posedge clk);
            model_edge(r_sp, r_en, r_rdy);
            #1;
            check($sformatf("rand%0d_%0d", seg, n), model_expect());
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
